// File: rtl/usb_tx_phy_gen.sv
// Parametrised USB transmit serializer: SYNC, bit stuffing, NRZI and SE0 EOP.
// Define USB_TX_ABORT_EN to make TxAbort_i send a bit-stuff-error abort sequence.
module usb_tx_phy_gen #(
    parameter int DW        = 8,
    parameter int SYNC_LEN  = 8,
    parameter int STUFF_LEN = 6,
    parameter int EOP_BITS  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fs_ce,
    input  logic          phy_mode,
    input  logic [DW-1:0] DataOut_i,
    input  logic          TxValid_i,
    input  logic          TxAbort_i,
    output logic          TxReady_o,
    output logic          txdp,
    output logic          txdn,
    output logic          txoe
);
    localparam int SRW = (SYNC_LEN > DW) ? SYNC_LEN : DW;
    localparam int BCW = $clog2(SRW);
    localparam logic [BCW-1:0] SYNC_LAST = BCW'(SYNC_LEN - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DW - 1);
    localparam logic [3:0]     STUFF_AT  = 4'(STUFF_LEN);
    localparam logic [2:0]     EOP_LAST  = 3'(EOP_BITS - 1);
    localparam logic [SRW-1:0] SYNC_PAT  = SRW'(1) << (SYNC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, SYNC, DATA, EOP, EOPJ
`ifdef USB_TX_ABORT_EN
        , ABRT
`endif
    } state_t;

    state_t         state;
    logic [SRW-1:0] sr;
    logic [BCW-1:0] bit_cnt;
    logic [3:0]     ones_cnt;
    logic [2:0]     eop_cnt;
    logic           done_pend;  // last bit of field sent, its stuff bit still owed
    logic           level;      // NRZI line level, 1 = J

    logic       stuff, raw, last_bit, boundary, level_nxt;
    logic [3:0] ones_nxt;

`ifdef USB_TX_ABORT_EN
    logic abort_req;
`else
    logic unused_abort;
    assign unused_abort = TxAbort_i;
`endif

    always_comb begin
        stuff     = (ones_cnt == STUFF_AT);
        raw       = stuff ? 1'b0 : sr[0];
        ones_nxt  = (stuff || !raw) ? 4'd0 : ones_cnt + 4'd1;
        last_bit  = (bit_cnt == ((state == SYNC) ? SYNC_LAST : DATA_LAST));
        // a field ends only once any stuff bit it triggered is on the wire
        boundary  = stuff ? done_pend : (last_bit && ones_nxt != STUFF_AT);
        level_nxt = raw ? level : ~level;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            eop_cnt   <= '0;
            done_pend <= 1'b0;
            level     <= 1'b1;
            txdp      <= 1'b1;
            txdn      <= 1'b0;
            txoe      <= 1'b1;
            TxReady_o <= 1'b0;
`ifdef USB_TX_ABORT_EN
            abort_req <= 1'b0;
`endif
        end else begin
            TxReady_o <= 1'b0;
`ifdef USB_TX_ABORT_EN
            if ((state == SYNC || state == DATA) && TxAbort_i)
                abort_req <= 1'b1;
`endif
            case (state)
                IDLE: if (TxValid_i) begin
                    sr        <= SYNC_PAT;
                    bit_cnt   <= '0;
                    ones_cnt  <= '0;
                    done_pend <= 1'b0;
                    level     <= 1'b1;
                    state     <= SYNC;
                end
                SYNC, DATA: if (fs_ce) begin
`ifdef USB_TX_ABORT_EN
                    if (abort_req || TxAbort_i) begin
                        // raw 1s with no stuffing: line holds, receiver sees a stuff error
                        txdp      <= level;
                        txdn      <= phy_mode & ~level;
                        txoe      <= 1'b0;
                        bit_cnt   <= BCW'(1);
                        abort_req <= 1'b0;
                        state     <= ABRT;
                    end else
`endif
                    begin
                        level     <= level_nxt;
                        txdp      <= level_nxt;
                        txdn      <= phy_mode & ~level_nxt;
                        txoe      <= 1'b0;
                        ones_cnt  <= ones_nxt;
                        done_pend <= !stuff && last_bit && ones_nxt == STUFF_AT;
                        if (!stuff) begin
                            sr      <= sr >> 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (boundary) begin
                            bit_cnt   <= '0;
                            done_pend <= 1'b0;
                            if (TxValid_i) begin
                                sr        <= SRW'(DataOut_i);
                                TxReady_o <= 1'b1;
                                state     <= DATA;
                            end else begin
                                eop_cnt <= '0;
                                state   <= EOP;
                            end
                        end
                    end
                end
                EOP: if (fs_ce) begin
                    txdp <= 1'b0;
                    txdn <= ~phy_mode;
                    txoe <= 1'b0;
                    if (eop_cnt == EOP_LAST) begin
                        eop_cnt <= '0;
                        state   <= EOPJ;
                    end else begin
                        eop_cnt <= eop_cnt + 3'd1;
                    end
                end
                EOPJ: if (fs_ce) begin
                    txdp <= 1'b1;
                    txdn <= 1'b0;
                    if (eop_cnt == 3'd0) begin
                        txoe    <= 1'b0;
                        eop_cnt <= 3'd1;
                    end else begin
                        txoe  <= 1'b1;
                        state <= IDLE;
                    end
                end
`ifdef USB_TX_ABORT_EN
                ABRT: if (fs_ce) begin
                    txdp <= level;
                    txdn <= phy_mode & ~level;
                    txoe <= 1'b0;
                    if (bit_cnt == BCW'(7)) begin
                        eop_cnt <= '0;
                        state   <= EOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_phy_gen.sv
// Bench for usb_tx_phy_gen: table packets, reset, random packets vs a line-level model.
module tb_usb_tx_phy_gen;
    logic clk = 0, rst = 0, fs_ce = 0, phy_mode = 1;
    logic [7:0]  d8 = '0;
    logic [15:0] d16 = '0;
    logic v8 = 0, v16 = 0, abort = 0;
    logic rdy8, dp8, dn8, oe8, rdy16, dp16, dn16, oe16;
    int total = 0, bad = 0, cyc = 0;

    typedef logic [2:0] sym_t;  // {txdp, txdn, txoe}
    sym_t exp_q[$], got_q[$];

    typedef struct {
        int               sel;
        logic             pm;
        int               n;
        logic [3:0][15:0] w;
        int               oe;
        int               gap;
    } vec_t;

    usb_tx_phy_gen dut (
        .clk(clk), .rst(rst), .fs_ce(fs_ce), .phy_mode(phy_mode),
        .DataOut_i(d8), .TxValid_i(v8), .TxAbort_i(abort),
        .TxReady_o(rdy8), .txdp(dp8), .txdn(dn8), .txoe(oe8)
    );

    usb_tx_phy_gen #(.DW(16), .SYNC_LEN(32)) dut_w (
        .clk(clk), .rst(rst), .fs_ce(fs_ce), .phy_mode(phy_mode),
        .DataOut_i(d16), .TxValid_i(v16), .TxAbort_i(1'b0),
        .TxReady_o(rdy16), .txdp(dp16), .txdn(dn16), .txoe(oe16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(output logic fs_was);
        fs_was = fs_ce;
        @(posedge clk);
        #1;
        cyc++;
        fs_ce = (cyc % 4 == 0);
    endtask

    function automatic sym_t line(input logic pm, input bit lvl);
        return lvl ? 3'b100 : (pm ? 3'b010 : 3'b000);
    endfunction

    // Expected line symbols per bit time: raw stream -> stuffing -> NRZI -> EOP.
    function automatic void model(input int sel, input logic pm, input logic [3:0][15:0] w,
                                  input int n, input int abort_at);
        int dw = sel ? 16 : 8;
        int sl = sel ? 32 : 8;
        int ones = 0;
        bit lvl = 1;
        bit raw_q[$], wire_q[$];
        for (int i = 0; i < sl; i++) raw_q.push_back(i == sl - 1);
        for (int k = 0; k < n; k++)
            for (int b = 0; b < dw; b++) raw_q.push_back(w[k][b]);
        foreach (raw_q[i]) begin
            wire_q.push_back(raw_q[i]);
            ones = raw_q[i] ? ones + 1 : 0;
            if (ones == 6) begin
                wire_q.push_back(1'b0);
                ones = 0;
            end
        end
        exp_q.delete();
        for (int i = 0; i < wire_q.size() && (abort_at == 0 || i < abort_at); i++) begin
            if (!wire_q[i]) lvl = ~lvl;
            exp_q.push_back(line(pm, lvl));
        end
        if (abort_at > 0) repeat (8) exp_q.push_back(line(pm, lvl));
        repeat (2) exp_q.push_back(pm ? 3'b000 : 3'b010);
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b101);
    endfunction

    task automatic run_pkt(input string name, input int sel, input logic pm,
                           input logic [3:0][15:0] w, input int n, input int abort_at,
                           input int exp_oe, input int exp_gap);
        int idx = 0, nrdy = 0, last_t = -1, gap_bad = 0, consec = 0;
        int nmis = 0, oe_low = 0, dn_hi = 0;
        logic prev_r = 0, fs_was, r;
        bit started = 0, done = 0;
        sym_t s;
        got_q.delete();
        phy_mode = pm;
        model(sel, pm, w, n, abort_at);
        d8 = w[0][7:0];
        d16 = w[0];
        if (sel != 0) v16 = 1; else v8 = 1;
        for (int c = 0; c < 6000 && !done; c++) begin
            tick(fs_was);
            if (c == 0 && n == 0) begin v8 = 0; v16 = 0; end
            abort = 0;
            r = (sel != 0) ? rdy16 : rdy8;
            if (r) begin
                nrdy++;
                if (prev_r) consec++;
                if (exp_gap > 0 && last_t >= 0 && cyc - last_t != exp_gap) gap_bad++;
                last_t = cyc;
                idx++;
                if (idx < n) begin
                    d8 = w[idx][7:0];
                    d16 = w[idx];
                end else if (abort_at == 0) begin
                    v8 = 0; v16 = 0;
                end
            end
            prev_r = r;
            if (fs_was) begin
                s = (sel != 0) ? {dp16, dn16, oe16} : {dp8, dn8, oe8};
                if (!s[0]) started = 1;
                if (started) begin
                    got_q.push_back(s);
                    if (s[0]) done = 1;
                end
                if (abort_at > 0 && got_q.size() == abort_at) abort = 1;
            end
        end
        v8 = 0; v16 = 0; abort = 0;
        chk({name, " done"}, int'(done), 1);
        chk({name, " len"}, got_q.size(), exp_q.size());
        foreach (got_q[i]) begin
            if (i < exp_q.size() && got_q[i] !== exp_q[i]) nmis++;
            if (!got_q[i][0]) oe_low++;
            if (got_q[i][1]) dn_hi++;
        end
        chk({name, " line mismatches"}, nmis, 0);
        chk({name, " ready count"}, nrdy, (abort_at > 0) ? 1 : n);
        chk({name, " ready back-to-back"}, consec, 0);
        if (exp_oe > 0) chk({name, " txoe low"}, oe_low, exp_oe);
        if (exp_gap > 0) chk({name, " ready spacing"}, gap_bad, 0);
        if (!pm) chk({name, " se txdn high"}, dn_hi, 2);
    endtask

    initial begin
        vec_t vt[7];
        logic fw;
        int se0;
        logic [3:0][15:0] rw;
        vt[0] = '{0, 1'b1, 1, {16'h0, 16'h0, 16'h0, 16'h00}, 19, 0};
        vt[1] = '{0, 1'b1, 1, {16'h0, 16'h0, 16'h0, 16'hFF}, 20, 0};
        vt[2] = '{0, 1'b0, 3, {16'h0, 16'h56, 16'h34, 16'h12}, 35, 32};
        vt[3] = '{0, 1'b1, 1, {16'h0, 16'h0, 16'h0, 16'hFC}, 20, 0};
        vt[4] = '{0, 1'b1, 0, {16'h0, 16'h0, 16'h0, 16'h0}, 11, 0};
        vt[5] = '{1, 1'b0, 1, {16'h0, 16'h0, 16'h0, 16'hA5C3}, 51, 0};
        vt[6] = '{1, 1'b1, 2, {16'h0, 16'h0, 16'h0001, 16'hFFFF}, 0, 0};

        repeat (3) tick(fw);
        chk("reset dut8", int'({dp8, dn8, oe8, rdy8}), 4'b1010);
        chk("reset dut16", int'({dp16, dn16, oe16, rdy16}), 4'b1010);
        rst = 1;
        repeat (4) tick(fw);

        foreach (vt[i])
            run_pkt($sformatf("vec%0d", i), vt[i].sel, vt[i].pm, vt[i].w, vt[i].n, 0,
                    vt[i].oe, vt[i].gap);

        // reset in the middle of a packet with TxValid_i still high
        phy_mode = 1; d8 = 8'h00; v8 = 1;
        repeat (50) tick(fw);
        chk("mid-packet oe", int'(oe8), 0);
        #2 rst = 0;
        #1 chk("reset mid-packet", int'({dp8, dn8, oe8, rdy8}), 4'b1010);
        v8 = 0;
        repeat (3) tick(fw);
        rst = 1;
        se0 = 0;
        repeat (100) begin
            tick(fw);
            if ((!dp8 && !dn8) || !oe8 || dn8) se0++;
        end
        chk("idle after reset", se0, 0);

        for (int k = 0; k < 24; k++) begin
            for (int j = 0; j < 4; j++)
                rw[j] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            run_pkt($sformatf("rand%0d", k), int'($urandom_range(0, 1)), 1'($urandom),
                    rw, int'($urandom_range(0, 3)), 0, 0, 0);
        end

`ifdef USB_TX_ABORT_EN
        run_pkt("abort", 0, 1'b1, {16'h0, 16'h0, 16'h0, 16'h0}, 3, 11, 22, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
